if_id_queue: RTL and testbench

Parametrised successor to the single-entry IF/ID pipeline register in the naive MIPS core. Holds up to DEPTH fetched (pc, instruction) pairs between fetch and decode, so fetch runs ahead while decode stalls. Adds valid/ready handshaking, a flush for branch/jump redirects, and an occupancy count. Sits between the PC/instruction-ROM fetch stage and the `id` decode stage.

---
 rtl/if_id_queue_pkg.sv | 10 +
 rtl/if_id_queue.sv | 60 ++++++
 tb/tb_if_id_queue.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared constants and sizing helpers for the fetch/decode queue.
package if_id_queue_pkg;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [31:0] NOP_INST = 32'h0;
  function automatic int ptr_w(int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry (pc, inst) queue between fetch and decode with flush and occupancy.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS_W,
  parameter int INST_W = INST_BUS_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       if_ready,
  input  logic                       stall,
  input  logic                       stall_aluop,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  assign if_ready = cnt_q < CW'(DEPTH);
  assign id_valid = cnt_q != '0;
  assign push = if_valid & if_ready;
  assign pop = id_valid & ~(stall | stall_aluop);
  // Empty head reads as zero so decode sees a NOP bubble.
  assign id_pc = id_valid ? pc_q[rd_ptr_q] : '0;
  assign id_inst = id_valid ? inst_q[rd_ptr_q] : '0;
  assign count = cnt_q;
  always_comb begin
    rd_ptr_d = flush ? '0 : !pop ? rd_ptr_q : (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    wr_ptr_d = flush ? '0 : !push ? wr_ptr_q : (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_q[wr_ptr_q] <= if_pc;
      inst_q[wr_ptr_q] <= if_inst;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed checks of the fetch/decode queue at DEPTH 2 and DEPTH 3.
module tb_if_id_queue;
  logic clk = 0;
  logic rst, flush, if_valid, stall, stall_aluop, if_ready, id_valid;
  logic [31:0] if_pc, if_inst, id_pc, id_inst;
  logic [1:0] count;
  logic v3, stall3, ready3, valid3, f3;
  logic [31:0] pc3, inst3, id_pc3, id_inst3;
  logic [1:0] count3;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .stall(stall), .stall_aluop(stall_aluop), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .count(count)
  );
  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(f3), .if_valid(v3), .if_pc(pc3), .if_inst(inst3),
    .if_ready(ready3), .stall(stall3), .stall_aluop(1'b0), .id_valid(valid3),
    .id_pc(id_pc3), .id_inst(id_inst3), .count(count3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] mk(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  task automatic offer(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc = pc;
    if_inst = mk(pc);
  endtask
  task automatic offer3(input logic v, input logic [31:0] pc);
    v3 = v;
    pc3 = pc;
    inst3 = mk(pc);
  endtask
  initial begin
    rst = 1; flush = 0; stall = 0; stall_aluop = 0; f3 = 0; stall3 = 0;
    offer(0, 0);
    offer3(0, 0);
    step;
    check("rst_valid", {31'd0, id_valid}, 0);
    check("rst_pc", id_pc, 0);
    check("rst_inst", id_inst, 0);
    check("rst_count", {30'd0, count}, 0);
    check("rst_ready", {31'd0, if_ready}, 1);
    check("rst_count3", {30'd0, count3}, 0);
    rst = 0;
    // fill under stall
    stall = 1;
    offer(1, 32'h100);
    step;
    check("fill1_count", {30'd0, count}, 1);
    check("fill1_pc", id_pc, 32'h100);
    check("fill1_ready", {31'd0, if_ready}, 1);
    offer(1, 32'h104);
    step;
    check("fill2_count", {30'd0, count}, 2);
    check("fill2_ready", {31'd0, if_ready}, 0);
    check("fill2_pc", id_pc, 32'h100);
    offer(1, 32'h108);
    step;
    check("full_count", {30'd0, count}, 2);
    check("full_pc", id_pc, 32'h100);
    check("full_inst", id_inst, mk(32'h100));
    // drain
    offer(0, 0);
    stall = 0;
    step;
    check("drain1_pc", id_pc, 32'h104);
    check("drain1_count", {30'd0, count}, 1);
    step;
    check("drain2_valid", {31'd0, id_valid}, 0);
    check("drain2_inst", id_inst, 0);
    check("drain2_count", {30'd0, count}, 0);
    // streaming push+pop
    for (int i = 0; i < 3; i++) begin
      offer(1, 32'h200 + 32'(4 * i));
      step;
      check("stream_count", {30'd0, count}, 1);
      check("stream_pc", id_pc, 32'h200 + 32'(4 * i));
    end
    offer(0, 0);
    step;
    check("stream_end_count", {30'd0, count}, 0);
    // flush with a full queue and a same-cycle offer
    stall = 1;
    offer(1, 32'h2F0);
    step;
    offer(1, 32'h2F4);
    step;
    check("pre_flush_count", {30'd0, count}, 2);
    flush = 1;
    offer(1, 32'h300);
    step;
    check("flush_count", {30'd0, count}, 0);
    check("flush_valid", {31'd0, id_valid}, 0);
    check("flush_ready", {31'd0, if_ready}, 1);
    step;
    check("flush_drop_push", {30'd0, count}, 0);
    flush = 0;
    offer(1, 32'h310);
    step;
    check("post_flush_count", {30'd0, count}, 1);
    check("post_flush_pc", id_pc, 32'h310);
    stall = 0;
    offer(0, 0);
    step;
    check("post_flush_drain", {30'd0, count}, 0);
    // stall_aluop alone
    stall_aluop = 1;
    offer(1, 32'h500);
    step;
    check("alu1_pc", id_pc, 32'h500);
    offer(1, 32'h504);
    step;
    check("alu2_count", {30'd0, count}, 2);
    check("alu2_ready", {31'd0, if_ready}, 0);
    offer(1, 32'h508);
    step;
    check("alu3_pc", id_pc, 32'h500);
    check("alu3_count", {30'd0, count}, 2);
    stall_aluop = 0;
    offer(0, 0);
    step;
    check("alu_rel_pc", id_pc, 32'h504);
    step;
    check("alu_rel_count", {30'd0, count}, 0);
    // reset overrides flush and push mid-operation
    offer(1, 32'h600);
    step;
    check("pre_rst_count", {30'd0, count}, 1);
    rst = 1;
    flush = 1;
    step;
    check("mid_rst_count", {30'd0, count}, 0);
    check("mid_rst_valid", {31'd0, id_valid}, 0);
    check("mid_rst_ready", {31'd0, if_ready}, 1);
    rst = 0;
    flush = 0;
    offer(0, 0);
    // DEPTH 3 pointer wrap
    stall3 = 1;
    for (int i = 0; i < 3; i++) begin
      offer3(1, 32'h400 + 32'(4 * i));
      step;
      check("d3_fill_count", {30'd0, count3}, 32'(i + 1));
      check("d3_fill_pc", id_pc3, 32'h400);
    end
    check("d3_full_ready", {31'd0, ready3}, 0);
    offer3(0, 0);
    stall3 = 0;
    for (int i = 1; i < 3; i++) begin
      step;
      check("d3_drain_pc", id_pc3, 32'h400 + 32'(4 * i));
      check("d3_drain_inst", id_inst3, mk(32'h400 + 32'(4 * i)));
    end
    step;
    check("d3_empty_valid", {31'd0, valid3}, 0);
    for (int i = 3; i < 7; i++) begin
      offer3(1, 32'h400 + 32'(4 * i));
      step;
      check("d3_stream_pc", id_pc3, 32'h400 + 32'(4 * i));
      check("d3_stream_count", {30'd0, count3}, 1);
    end
    offer3(0, 0);
    step;
    check("d3_end_count", {30'd0, count3}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
